// File: rtl/mem_copy_dma.sv
// mem_copy_dma: single-port RAM word copier (READ/WRITE alternating).
// Copies len words from src.. to dst.., ascending, addresses wrap mod 2^ADDR_W.
// Optional feature macro DMA_FILL_EN: adds fill/fill_data inputs; a fill
// request skips READ and writes fill_data to every destination word.
module mem_copy_dma #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
`ifdef DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] Dir,
  output logic              RE,
  output logic              WE,
  output logic [DATA_W-1:0] Datoin,
  input  logic [DATA_W-1:0] Datoout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   i, i_inc;   // one bit wider than an address: len can be 2^ADDR_W
  logic [DATA_W-1:0] hold;
  logic              fill_q;
  logic [DATA_W-1:0] fill_data_q;
  logic              fill_req;
  logic [DATA_W-1:0] fill_data_req;

`ifdef DMA_FILL_EN
  assign fill_req      = fill;
  assign fill_data_req = fill_data;
`else
  assign fill_req      = 1'b0;
  assign fill_data_req = '0;
`endif

  assign i_inc = i + ONE;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; fill transfers loop WRITE->WRITE, copies alternate
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len == '0) ? DONE : (fill_req ? WRITE : READ);
      READ:  state_nxt = WRITE;
      WRITE: state_nxt = (i_inc < len_q) ? (fill_q ? WRITE : READ) : DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset zeroes them immediately
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    RE     = 1'b0;
    WE     = 1'b0;
    Dir    = '0;
    Datoin = '0;
    case (state)
      READ: begin
        busy = 1'b1;
        RE   = 1'b1;
        Dir  = src_q + i[ADDR_W-1:0];
      end
      WRITE: begin
        busy   = 1'b1;
        WE     = 1'b1;
        Dir    = dst_q + i[ADDR_W-1:0];
        Datoin = fill_q ? fill_data_q : hold;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request latch, read holding register, word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      i           <= '0;
      hold        <= '0;
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_q       <= src;
          dst_q       <= dst;
          len_q       <= len;
          i           <= '0;
          fill_q      <= fill_req;
          fill_data_q <= fill_data_req;
        end
        READ:  hold <= Datoout;
        WRITE: i    <= i_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: RAM model + shadow reference model + write/read scoreboard.
module tb_mem_copy_dma;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src = '0, dst = '0;
  logic [AW:0]   len = '0;
`ifdef DMA_FILL_EN
  logic          fill = 1'b0;
  logic [DW-1:0] fill_data = '0;
`endif
  logic          busy, done, RE, WE;
  logic [AW-1:0] Dir;
  logic [DW-1:0] Datoin, Datoout;

  mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
`ifdef DMA_FILL_EN
    .fill(fill), .fill_data(fill_data),
`endif
    .busy(busy), .done(done), .Dir(Dir), .RE(RE), .WE(WE),
    .Datoin(Datoin), .Datoout(Datoout)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on rising edge; preload/poke via flags
  logic [DW-1:0] mem [NW];
  logic [DW-1:0] sh  [NW];
  logic          init_req = 1'b0, poke_en = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [DW-1:0] poke_d = '0;

  assign Datoout = mem[Dir];

  always @(posedge clk) begin
    if (init_req) for (int j = 0; j < NW; j++) mem[j] <= DW'(j + 100);
    else if (poke_en) mem[poke_a] <= poke_d;
    if (WE) mem[Dir] <= Datoin;
  end

  int pass_cnt = 0, tot_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else pass_cnt++;
  endtask

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           wq[$];
  logic [AW-1:0] rq[$];

  // Scoreboard monitor: every RAM access is popped against the model's order
  always @(negedge clk) begin
    wr_t w;
    if (RE && WE) chk("re_we_both", 1, 0);
    if (RE) begin
      if (rq.size() == 0) chk("rd_unexpected", {59'd0, Dir}, 64'hffff);
      else chk("rd_addr", Dir, rq.pop_front());
    end
    if (WE) begin
      if (wq.size() == 0) chk("wr_unexpected", {59'd0, Dir}, 64'hffff);
      else begin
        w = wq.pop_front();
        chk("wr_addr", Dir, w.a);
        chk("wr_data", Datoin, w.d);
      end
    end
    if (RE || WE || done) chk("busy", busy, RE | WE);
  end

  task automatic preload();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
    for (int j = 0; j < NW; j++) sh[j] = DW'(j + 100);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk) begin poke_en = 1'b1; poke_a = a; poke_d = d; end
    @(negedge clk) poke_en = 1'b0;
    sh[a] = d;
  endtask

  // Reference model: strictly ascending word-by-word copy on the shadow RAM
  task automatic push_exp(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW:0] l, input logic f, input logic [DW-1:0] fd);
    logic [AW-1:0] ra, wa;
    wr_t w;
    for (int j = 0; j < int'(l); j++) begin
      ra = s + AW'(j);
      wa = d + AW'(j);
      w.a = wa;
      w.d = f ? fd : sh[ra];
      sh[wa] = w.d;
      wq.push_back(w);
      if (!f) rq.push_back(ra);
    end
  endtask

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW:0] l, input logic f, input logic [DW-1:0] fd,
                          input int exp_lat);
    int c, bad;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
`ifdef DMA_FILL_EN
    fill = f; fill_data = fd;
`endif
    push_exp(s, d, l, f, fd);
    @(posedge clk);              // acceptance edge k
    @(negedge clk);
    // inputs scrambled after acceptance must not matter
    start = 1'b0; src = AW'($urandom); dst = AW'($urandom); len = (AW+1)'($urandom);
`ifdef DMA_FILL_EN
    fill = 1'($urandom); fill_data = $urandom;
`endif
    c = 0;
    while (!done && c < 200) begin
      start = (c == 1 && exp_lat >= 3);   // start while busy is ignored
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("done_latency", c, exp_lat);
    @(negedge clk);
    chk("done_one_cycle", {done, busy}, 2'b00);
    chk("idle_bus", {Dir, Datoin, RE, WE}, '0);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    bad = 0;
    for (int j = 0; j < NW; j++) if (mem[j] !== sh[j]) bad++;
    chk("ram_vs_model", bad, 0);
  endtask

  typedef struct {
    logic [AW-1:0] s, d;
    logic [AW:0]   l;
    logic          pk;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    int            lat;
    logic [AW-1:0] ca;
    logic [DW-1:0] cv;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{s:2,  d:20, l:4,  pk:0, pa:0,  pd:0,            lat:8,  ca:23, cv:105};
    vt[1] = '{s:2,  d:20, l:0,  pk:0, pa:0,  pd:0,            lat:0,  ca:20, cv:120};
    vt[2] = '{s:30, d:5,  l:3,  pk:0, pa:0,  pd:0,            lat:6,  ca:7,  cv:100};
    vt[3] = '{s:10, d:11, l:3,  pk:1, pa:10, pd:32'hAAAA5555, lat:6,  ca:13, cv:32'hAAAA5555};
    vt[4] = '{s:3,  d:17, l:32, pk:0, pa:0,  pd:0,            lat:64, ca:16, cv:106};

    // reset state
    #1;
    chk("reset_outputs", {busy, done, RE, WE, Dir, Datoin}, '0);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      preload();
      if (vt[v].pk) poke(vt[v].pa, vt[v].pd);
      run_copy(vt[v].s, vt[v].d, vt[v].l, 1'b0, '0, vt[v].lat);
      chk($sformatf("vec%0d_word", v), mem[vt[v].ca], vt[v].cv);
    end

    // reset during the second WRITE of a len=4 copy
    preload();
    @(negedge clk) begin start = 1'b1; src = 2; dst = 20; len = 4; end
    push_exp(2, 20, 4, 1'b0, '0);
    @(posedge clk);              // k: READ0 follows
    #1 start = 1'b0;
    @(posedge clk);              // WRITE0
    @(posedge clk);              // READ1 (mem[20] written here)
    @(posedge clk);              // WRITE1
    #2 rst_n = 1'b0;
    #1 chk("midreset_outputs", {busy, done, RE, WE, Dir, Datoin}, '0);
    wq.delete();
    rq.delete();
    chk("midreset_first_word", mem[20], 102);
    chk("midreset_second_word", mem[21], 121);
    chk("midreset_third_word", mem[22], 122);
    @(negedge clk) rst_n = 1'b1;
    preload();
    run_copy(2, 24, 4, 1'b0, '0, 8);
    chk("after_reset_word", mem[27], 105);

`ifdef DMA_FILL_EN
    preload();
    run_copy(0, 8, 5, 1'b1, 32'hDEADBEEF, 5);
    chk("fill_last_word", mem[12], 32'hDEADBEEF);
    chk("fill_neighbour", mem[13], 113);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, RAM word-address width (32 words addressable).
REQ-002 The block SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 The block SHALL have port start, input, 1, copy request; sampled only in IDLE.
REQ-006 The block SHALL have port src, input, ADDR_W, first source word address; latched on accepted start.
REQ-007 The block SHALL have port dst, input, ADDR_W, first destination word address; latched on accepted start.
REQ-008 The block SHALL have port len, input, ADDR_W+1, word count 0..2^ADDR_W; latched on accepted start.
REQ-009 The block SHALL have port busy, output, 1, high in READ and WRITE.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port Dir, output, ADDR_W, RAM address.
REQ-012 The block SHALL have port RE, output, 1, RAM read enable.
REQ-013 The block SHALL have port WE, output, 1, RAM write enable.
REQ-014 The block SHALL have port Datoin, output, DATA_W, RAM write data.
REQ-015 The block SHALL have port Datoout, input, DATA_W, RAM read data, combinationally valid while RE high.

Function
REQ-016 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-017 In IDLE, start=1 at a clock edge SHALL latch src/dst/len, clear word index i, and go to READ (len>0) or DONE (len=0).
REQ-018 In READ, outputs SHALL be RE=1, WE=0, Dir=src+i mod 2^ADDR_W; at the edge Datoout SHALL be captured into a holding register; next state WRITE.
REQ-019 In WRITE, outputs SHALL be RE=0, WE=1, Dir=dst+i mod 2^ADDR_W, Datoin=holding register; at the edge i increments; next state READ if i+1<len, else DONE.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, busy 0; next state IDLE.
REQ-021 In IDLE and DONE, RE=0, WE=0, Dir=0, Datoin=0.
REQ-022 RE and WE SHALL never be high in the same cycle.
REQ-023 Latency: start accepted at edge k SHALL give done high during cycle k+2*len+1 (len=0: cycle k+1).
REQ-024 start while not in IDLE SHALL be ignored; src/dst/len changes after acceptance SHALL have no effect.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W; len=2^ADDR_W SHALL copy every word once.
REQ-026 Overlapping regions SHALL be copied strictly ascending, word by word (dst=src+1 replicates mem[src] forward); no overlap correction.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, i=0, holding register=0, busy=0, done=0, RE=0, WE=0, Dir=0, Datoin=0, including mid-transfer; words already written remain written.
REQ-028 After rst_n deasserts, the first start SHALL be accepted no earlier than the next rising edge.

Configuration
REQ-029 Macro DMA_FILL_EN, when defined, SHALL add inputs fill (1) and fill_data (DATA_W), latched on accepted start; fill=1 SHALL skip READ (RE stays 0), write fill_data to dst..dst+len-1 one word per cycle, giving done at cycle k+len+1.
REQ-030 Without DMA_FILL_EN, ports fill/fill_data SHALL be absent and behaviour SHALL be copy-only per REQ-016..026.

Verification
REQ-031 RAM preloaded mem[i]=i+100; start src=2,dst=20,len=4 -> mem[20..23]=102..105, done exactly at cycle k+9, RE/WE alternate, never both high.
REQ-032 start len=0 -> no RE/WE pulse, done at cycle k+1, RAM unchanged.
REQ-033 src=30,dst=5,len=3 -> reads from 30,31,0; mem[5..7]=mem[30],mem[31],mem[0].
REQ-034 dst=src+1=11, len=3, mem[10]=0xAAAA5555 -> mem[11..13]=0xAAAA5555.
REQ-035 rst_n low during second WRITE of len=4 copy -> outputs zero immediately, first dst word written, later words untouched; new start afterwards completes normally.
REQ-036 (DMA_FILL_EN) fill=1, fill_data=0xDEADBEEF, dst=8, len=5 -> mem[8..12]=0xDEADBEEF, RE never high, done at cycle k+6.
